// File: rtl/branch_predictor_ctrl_if.sv
// Fetch-side lookup and execute-side resolve signals of the branch predictor.
interface branch_predictor_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      i_pc_f;
    logic             o_pred_taken_f;
    logic [31:0]      o_pred_target_f;
    logic             i_branch_e;
    logic             i_branch_taken_e;
    logic [31:0]      i_pc_e;
    logic [31:0]      i_pc_plus4_e;
    logic [31:0]      i_target_e;
    logic             i_pred_taken_e;
    logic [31:0]      i_pred_target_e;
    logic             i_stall_e;
    logic             o_mispredict_e;
    logic [31:0]      o_redirect_pc_e;
    logic [CNT_W-1:0] o_branch_cnt;
    logic [CNT_W-1:0] o_mispred_cnt;

    modport master (
        output i_pc_f, i_branch_e, i_branch_taken_e, i_pc_e, i_pc_plus4_e,
               i_target_e, i_pred_taken_e, i_pred_target_e, i_stall_e,
        input  o_pred_taken_f, o_pred_target_f, o_mispredict_e,
               o_redirect_pc_e, o_branch_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_pc_f, i_branch_e, i_branch_taken_e, i_pc_e, i_pc_plus4_e,
               i_target_e, i_pred_taken_e, i_pred_target_e, i_stall_e,
        output o_pred_taken_f, o_pred_target_f, o_mispredict_e,
               o_redirect_pc_e, o_branch_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// Direct-mapped 2-bit counter predictor with tagged BTB and mispredict redirect.
//
// Per-entry counter states:
//   state    | meaning
//   SNT (00) | strongly not taken
//   WNT (01) | weakly not taken (reset value)
//   WT  (10) | weakly taken (value on allocation)
//   ST  (11) | strongly taken
module branch_predictor_ctrl #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    branch_predictor_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e;
    logic             upd, mismatch;
    logic [1:0]       ctr_nxt;

    assign idx_f = bus.i_pc_f[IDX_W+1:2];
    assign tag_f = bus.i_pc_f[IDX_W+TAG_W+1:IDX_W+2];
    assign idx_e = bus.i_pc_e[IDX_W+1:2];
    assign tag_e = bus.i_pc_e[IDX_W+TAG_W+1:IDX_W+2];

    // Bits outside index/tag fields do not take part in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.i_pc_f[31:IDX_W+TAG_W+2], bus.i_pc_f[1:0],
                              bus.i_pc_e[31:IDX_W+TAG_W+2], bus.i_pc_e[1:0]};

    assign hit_f    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign upd      = bus.i_branch_e && !bus.i_stall_e;
    assign mismatch = (bus.i_branch_taken_e != bus.i_pred_taken_e) ||
                      (bus.i_branch_taken_e && bus.i_pred_taken_e &&
                       (bus.i_pred_target_e != bus.i_target_e));

    // Next counter state for the entry being trained; a miss allocates at WT.
    always_comb begin
        ctr_nxt = WT;
        if (hit_e) begin
            unique case (ctr_q[idx_e])
                SNT:     ctr_nxt = bus.i_branch_taken_e ? WNT : SNT;
                WNT:     ctr_nxt = bus.i_branch_taken_e ? WT  : SNT;
                WT:      ctr_nxt = bus.i_branch_taken_e ? ST  : WNT;
                default: ctr_nxt = bus.i_branch_taken_e ? ST  : WT;
            endcase
        end
    end

    // Table and performance counter state; reset overrides any pending update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (upd) begin
            if (hit_e || bus.i_branch_taken_e) begin
                valid_q[idx_e] <= 1'b1;
                tag_q[idx_e]   <= tag_e;
                ctr_q[idx_e]   <= ctr_nxt;
                if (bus.i_branch_taken_e)
                    target_q[idx_e] <= bus.i_target_e;
            end
            if (branch_cnt_q != {CNT_W{1'b1}})
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mismatch && (mispred_cnt_q != {CNT_W{1'b1}}))
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    // Lookup and resolve outputs, purely combinational from current state.
    always_comb begin
        bus.o_pred_taken_f  = hit_f && ctr_q[idx_f][1];
        bus.o_pred_target_f = hit_f ? target_q[idx_f] : 32'd0;
        bus.o_mispredict_e  = upd && mismatch;
        bus.o_redirect_pc_e = bus.i_branch_taken_e ? bus.i_target_e : bus.i_pc_plus4_e;
        bus.o_branch_cnt    = branch_cnt_q;
        bus.o_mispred_cnt   = mispred_cnt_q;
    end
endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed table-driven bench for branch_predictor_ctrl (narrow perf counters).
module tb_branch_predictor_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_ctrl_if #(.CNT_W(CNT_W)) bus ();

    branch_predictor_ctrl #(.IDX_W(4), .TAG_W(8), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc_f;
        logic        br;
        logic        tk;
        logic [31:0] pc_e;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        stall;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_redir;
        int          e_bc;
        int          e_mc;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [31:0] pc_f, input logic br, input logic tk,
                                input logic [31:0] pc_e, input logic [31:0] tgt,
                                input logic ptk, input logic [31:0] ptgt, input logic stall,
                                input logic e_ptk, input logic [31:0] e_ptgt,
                                input logic e_mis, input logic [31:0] e_redir,
                                input int e_bc, input int e_mc);
        vec_t v;
        v.pc_f = pc_f; v.br = br; v.tk = tk; v.pc_e = pc_e; v.tgt = tgt;
        v.ptk = ptk; v.ptgt = ptgt; v.stall = stall;
        v.e_ptk = e_ptk; v.e_ptgt = e_ptgt; v.e_mis = e_mis; v.e_redir = e_redir;
        v.e_bc = e_bc; v.e_mc = e_mc;
        tbl.push_back(v);
    endfunction

    // Idle row: no branch, but the piped prediction disagrees so a missing gate shows.
    function automatic void idle(input logic [31:0] pc_f, input logic e_ptk,
                                 input logic [31:0] e_ptgt, input int bc, input int mc);
        add(pc_f, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b0,
            e_ptk, e_ptgt, 1'b0, 32'h104, bc, mc);
    endfunction

    task automatic drive(input logic [31:0] pc_f, input logic br, input logic tk,
                         input logic [31:0] pc_e, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt, input logic stall);
        bus.i_pc_f = pc_f;
        bus.i_branch_e = br;
        bus.i_branch_taken_e = tk;
        bus.i_pc_e = pc_e;
        bus.i_pc_plus4_e = pc_e + 32'd4;
        bus.i_target_e = tgt;
        bus.i_pred_taken_e = ptk;
        bus.i_pred_target_e = ptgt;
        bus.i_stall_e = stall;
    endtask

    initial begin
        drive(32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h100, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        #1;
        chk("reset_pred_taken", 32'(bus.o_pred_taken_f), 32'd0);
        chk("reset_pred_target", bus.o_pred_target_f, 32'd0);
        chk("reset_mispredict", 32'(bus.o_mispredict_e), 32'd0);
        chk("reset_branch_cnt", 32'(bus.o_branch_cnt), 32'd0);
        chk("reset_mispred_cnt", 32'(bus.o_mispred_cnt), 32'd0);

        // pc_f, br, tk, pc_e, tgt, ptk, ptgt, stall | ptk_f, tgt_f, mis, redir, bc, mc
        idle(32'h100, 0, 32'h0, 0, 0);
        add(32'h100, 1, 1, 32'h100, 32'h140, 0, 32'h0,   0, 0, 32'h0,   1, 32'h140, 0, 0);
        idle(32'h100, 1, 32'h140, 1, 1);
        add(32'h100, 1, 0, 32'h100, 32'h140, 1, 32'h140, 0, 1, 32'h140, 1, 32'h104, 1, 1);
        add(32'h100, 1, 0, 32'h100, 32'h140, 0, 32'h0,   0, 0, 32'h140, 0, 32'h104, 2, 2);
        idle(32'h100, 0, 32'h140, 3, 2);
        add(32'h100, 1, 1, 32'h100, 32'h140, 0, 32'h0,   0, 0, 32'h140, 1, 32'h140, 3, 2);
        add(32'h100, 1, 1, 32'h100, 32'h140, 0, 32'h0,   0, 0, 32'h140, 1, 32'h140, 4, 3);
        add(32'h100, 1, 1, 32'h100, 32'h140, 1, 32'h140, 0, 1, 32'h140, 0, 32'h140, 5, 4);
        add(32'h100, 1, 1, 32'h100, 32'h140, 1, 32'h140, 0, 1, 32'h140, 0, 32'h140, 6, 4);
        add(32'h100, 1, 0, 32'h100, 32'h140, 1, 32'h140, 0, 1, 32'h140, 1, 32'h104, 7, 4);
        idle(32'h100, 1, 32'h140, 8, 5);
        idle(32'h1100, 0, 32'h0, 8, 5);
        add(32'h1100, 1, 1, 32'h1100, 32'h1200, 0, 32'h0, 0, 0, 32'h0, 1, 32'h1200, 8, 5);
        idle(32'h100, 0, 32'h0, 9, 6);
        idle(32'h1100, 1, 32'h1200, 9, 6);
        add(32'h100, 1, 1, 32'h100, 32'h140, 0, 32'h0,   0, 0, 32'h0,   1, 32'h140, 9, 6);
        add(32'h100, 1, 1, 32'h100, 32'h180, 1, 32'h140, 0, 1, 32'h140, 1, 32'h180, 10, 7);
        idle(32'h100, 1, 32'h180, 11, 8);
        for (int i = 0; i < 3; i++)
            add(32'h100, 1, 0, 32'h100, 32'h180, 1, 32'h180, 1, 1, 32'h180, 0, 32'h104, 11, 8);
        add(32'h100, 1, 0, 32'h100, 32'h180, 1, 32'h180, 0, 1, 32'h180, 1, 32'h104, 11, 8);
        idle(32'h100, 1, 32'h180, 12, 9);
        add(32'h100, 1, 0, 32'h100, 32'h180, 1, 32'h180, 0, 1, 32'h180, 1, 32'h104, 12, 9);
        idle(32'h100, 0, 32'h180, 13, 10);

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].pc_f, tbl[k].br, tbl[k].tk, tbl[k].pc_e, tbl[k].tgt,
                  tbl[k].ptk, tbl[k].ptgt, tbl[k].stall);
            #1;
            chk($sformatf("row%0d_pred_taken", k), 32'(bus.o_pred_taken_f), 32'(tbl[k].e_ptk));
            chk($sformatf("row%0d_pred_target", k), bus.o_pred_target_f, tbl[k].e_ptgt);
            chk($sformatf("row%0d_mispredict", k), 32'(bus.o_mispredict_e), 32'(tbl[k].e_mis));
            chk($sformatf("row%0d_redirect", k), bus.o_redirect_pc_e, tbl[k].e_redir);
            chk($sformatf("row%0d_branch_cnt", k), 32'(bus.o_branch_cnt), 32'(tbl[k].e_bc));
            chk($sformatf("row%0d_mispred_cnt", k), 32'(bus.o_mispred_cnt), 32'(tbl[k].e_mc));
        end

        // Reset coinciding with a taken branch: the update is dropped.
        @(negedge clk);
        rst = 1'b1;
        drive(32'h100, 1, 1, 32'h200, 32'h300, 0, 32'h0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h100, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        #1;
        chk("midrst_pred_taken", 32'(bus.o_pred_taken_f), 32'd0);
        chk("midrst_pred_target", bus.o_pred_target_f, 32'd0);
        chk("midrst_mispredict", 32'(bus.o_mispredict_e), 32'd0);
        chk("midrst_branch_cnt", 32'(bus.o_branch_cnt), 32'd0);
        chk("midrst_mispred_cnt", 32'(bus.o_mispred_cnt), 32'd0);
        bus.i_pc_f = 32'h200;
        #1;
        chk("midrst_no_alloc", 32'(bus.o_pred_taken_f), 32'd0);

        // Perf counters saturate at all-ones instead of wrapping.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(32'h0, 1, 1, 32'h300, 32'h400, 0, 32'h0, 0);
        end
        @(negedge clk);
        drive(32'h300, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        #1;
        chk("sat_branch_cnt", 32'(bus.o_branch_cnt), 32'd15);
        chk("sat_mispred_cnt", 32'(bus.o_mispred_cnt), 32'd15);
        chk("sat_pred_taken", 32'(bus.o_pred_taken_f), 32'd1);
        chk("sat_pred_target", bus.o_pred_target_f, 32'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor_ctrl.md
Name: branch_predictor_ctrl

Overview:
Dynamic branch prediction and redirect controller for the 5-stage RV32I pipeline.
- Fetch: looks up a direct-mapped table of 2-bit saturating counters plus a tagged branch-target buffer, and supplies a predicted next PC.
- Execute: compares the resolved outcome (branch decision output) with the prediction carried down the pipe, and raises mispredict/redirect for the hazard unit.
- Trains the table and keeps branch/mispredict performance counters.

Parameters:
IDX_W, 4, index width; table has 2^IDX_W entries, index = PC[IDX_W+1:2]
TAG_W, 8, tag width; tag = PC[IDX_W+TAG_W+1:IDX_W+2]
CNT_W, 32, performance counter width

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_pc_f  in  32  fetch-stage PC
o_pred_taken_f  out  1  predict taken for i_pc_f
o_pred_target_f  out  32  predicted target (valid when o_pred_taken_f=1)
i_branch_e  in  1  conditional branch in execute
i_branch_taken_e  in  1  resolved outcome from branch decision
i_pc_e  in  32  execute-stage PC of the branch
i_pc_plus4_e  in  32  execute-stage PC+4
i_target_e  in  32  resolved branch target
i_pred_taken_e  in  1  prediction made in fetch, piped to E
i_pred_target_e  in  32  predicted target, piped to E
i_stall_e  in  1  execute stage held this cycle
o_mispredict_e  out  1  flush F/D and redirect fetch
o_redirect_pc_e  out  32  correct next PC on mispredict
o_branch_cnt  out  CNT_W  resolved branches
o_mispred_cnt  out  CNT_W  mispredicted branches

Behaviour:
- State per entry: valid (1b), tag (TAG_W), target (32b), ctr (2b). All are registers, so there is no RAM latency.
- Reset (i_rst=1 at edge), state after reset:
  - all valid=0, all ctr=2'b01, tag/target=0, both perf counters=0.
  - o_pred_taken_f=0 and o_mispredict_e=0 in the first cycle after reset, given inputs are 0.
  - Reset mid-operation discards any pending update that cycle.
- Lookup (combinational, zero latency):
  - hit = valid[idx_f] && tag[idx_f]==tag(i_pc_f)
  - o_pred_taken_f = hit && ctr[idx_f][1]
  - o_pred_target_f = hit ? target[idx_f] : 0
- Resolve (combinational), with upd = i_branch_e && !i_stall_e:
  - mismatch = (i_branch_taken_e != i_pred_taken_e) || (i_branch_taken_e && i_pred_taken_e && i_pred_target_e != i_target_e)
  - o_mispredict_e = upd && mismatch
  - o_redirect_pc_e = i_branch_taken_e ? i_target_e : i_pc_plus4_e. It is a don't-care when o_mispredict_e=0 but is still driven by the same expression.
  - Stalled branch produces no mispredict. It asserts exactly once, in the cycle the stall drops.
- Update (rising edge, when upd=1, idx_e/tag_e from i_pc_e):
  - Entry hit (valid && tag match):
    - taken: ctr = min(ctr+1, 3), target = i_target_e
    - not taken: ctr = max(ctr-1, 0)
    - target unchanged when not taken
  - Entry miss, taken: allocate/replace. valid=1, tag=tag_e, target=i_target_e, ctr=2'b10.
  - Entry miss, not taken: no change (no allocation).
  - o_branch_cnt += 1; o_mispred_cnt += mismatch. Both saturate at all-ones and do not wrap.
- Simultaneous lookup and update of the same index in one cycle: lookup returns the pre-update value. The new value is visible from the next cycle.
- i_branch_e=0 or i_stall_e=1: no state change; counters hold.
- Counter FSM per entry:
  - states SNT(00), WNT(01), WT(10), ST(11)
  - taken moves up one state, not-taken moves down one state
  - saturates at both ends

Test Plan:
- Reset then i_pc_f=0x100 -> o_pred_taken_f=0, o_pred_target_f=0; counters 0.
- Branch at 0x100, target 0x140, taken, i_pred_taken_e=0 -> o_mispredict_e=1, o_redirect_pc_e=0x140; next cycle i_pc_f=0x100 gives pred_taken=1, target=0x140, ctr=10; o_branch_cnt=1, o_mispred_cnt=1.
- Same branch resolved not-taken twice with correct piped predictions (1, then 0) -> first mispredict redirects to 0x104, ctr 10->01; second no mispredict, ctr 01->00; subsequent predict 0. Three taken outcomes saturate ctr at 11; a fourth keeps 11.
- Aliasing, PC 0x100 vs 0x1100 (same idx, different tag): lookup of 0x1100 -> no hit, pred 0. Taken resolve of 0x1100 replaces entry, after which 0x100 no longer hits.
- Target mismatch: predicted taken to 0x140, resolved taken to 0x180 -> o_mispredict_e=1, redirect 0x180, target updated to 0x180.
- i_stall_e=1 for 3 cycles with mispredicting branch -> mispredict low and no updates during stall, one pulse on release; counters +1 only. Same-cycle read/write of one index returns the old value.
